pedestrian_request: RTL

//  Conditions the raw pedestrian push-button and drives the bt input of the

---
 rtl/pedestrian_request.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pedestrian_request.sv
// Pedestrian push-button conditioner for the semaforo controller.
// The raw button passes through a two-flop synchroniser and a counting
// debouncer. A rising edge of the debounced level is a press. The FSM turns
// one press into a single held request (bt_req) that stays up until ack.
// After each service, a lockout window discards further presses so that a
// held or hammered button cannot starve the main road.
module pedestrian_request #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,  // 1..255
  parameter int unsigned LOCKOUT_CYCLES  = 8   // 0..255, 0 disables lockout
) (
  input  logic       clk,
  input  logic       rst,          // synchronous, active-low
  input  logic       bt_raw,
  input  logic       ack,
  output logic       bt_req,
  output logic       busy,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] LOCK_INIT = 8'(LOCKOUT_CYCLES);
  localparam logic [7:0] COUNT_MAX = 8'hFF;

  logic       sync1;
  logic       sync2;
  logic       db_level;
  logic       db_prev;
  logic [7:0] db_cnt;
  logic       press;

  state_t     state;
  state_t     state_next;
  logic [7:0] lock_cnt;
  logic [7:0] lock_next;
  logic [7:0] count_next;
  logic       bt_req_next;

  // Two-flop synchroniser for the asynchronous button level.
  // NOTE: every clocked block uses non-blocking assignments, so each flop
  // samples the value its source held before the edge. With blocking
  // assignments, sync2 would collapse into sync1 in a single cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bt_raw;
      sync2 <= sync1;
    end
  end

  // Debouncer: the level flips only after DEBOUNCE_CYCLES consecutive
  // samples at the opposite level; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_level <= 1'b0;
      db_cnt   <= 8'd0;
    end else if (sync2 == db_level) begin
      db_cnt <= 8'd0;
    end else if (db_cnt == DB_LAST) begin
      db_level <= sync2;
      db_cnt   <= 8'd0;
    end else begin
      db_cnt <= db_cnt + 8'd1;
    end
  end

  // One-cycle-delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_prev <= 1'b0;
    end else begin
      db_prev <= db_level;
    end
  end

  // A press is the rising edge of the debounced level. Release edges are
  // ignored, so the button must go back to 0 before it can press again.
  assign press = db_level & ~db_prev;

  // FSM state, lockout timer, press counter and request flop.
  // NOTE: reset clears every register here, including the counter and
  // the request. A pending request must never outlive a reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      lock_cnt    <= 8'd0;
      press_count <= 8'd0;
      bt_req      <= 1'b0;
    end else begin
      state       <= state_next;
      lock_cnt    <= lock_next;
      press_count <= count_next;
      bt_req      <= bt_req_next;
    end
  end

  // Next-state logic: accept a press in IDLE, hold until ack, then lock out.
  // NOTE: every output of this block gets a default before the case. A path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    lock_next  = lock_cnt;
    count_next = press_count;

    case (state)
      IDLE: begin
        if (press) begin
          state_next = PENDING;
          if (press_count != COUNT_MAX) begin
            count_next = press_count + 8'd1;
          end
        end
      end

      PENDING: begin
        // A press here is merged into the outstanding request. If it lands
        // together with ack, ack wins and the press is lost.
        if (ack) begin
          if (LOCKOUT_CYCLES == 0) begin
            state_next = IDLE;
          end else begin
            state_next = LOCKOUT;
            lock_next  = LOCK_INIT;
          end
        end
      end

      LOCKOUT: begin
        // Entered with lock_cnt = LOCKOUT_CYCLES. Leaving on the edge where
        // it reads 1 keeps the state here for exactly that many cycles.
        lock_next = lock_cnt - 8'd1;
        if (lock_cnt == 8'd1) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        lock_next  = 8'd0;
      end
    endcase
  end

  // bt_req is registered from the current state. It therefore rises one
  // edge after PENDING is entered. It drops on the same edge that
  // samples ack, so the controller never sees a stale request.
  always_comb begin
    bt_req_next = (state == PENDING) && !ack;
  end

  assign busy = (state != IDLE);

endmodule
